// File: rtl/dot_prod_vector_streamer.sv
// rtl/dot_prod_vector_streamer.sv - source-side sequencer for the dot-product accelerator
//
// Buffers vectors A and B written by the host, pulses init_loading_pulse / start
// toward the controller, streams element pairs, then captures and holds the result.
//
// Optional feature macro: STREAMER_IRQ_EN (sticky completion interrupt on irq).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_en/sel/addr/data host element write (sel 0 = A, 1 = B)
//   len, go             vector length (1..DEPTH) and start-streaming command
//   init_loading_pulse  one-cycle pulse after the first write from IDLE
//   start               one-cycle pulse while arming the controller
//   a_data, b_data      current element pair, qualified by vector_valid
//   vector_valid, last  pair valid / final pair
//   vec_ready           datapath accepts the current pair
//   done_in, result_in  controller completion and dot-product sum
//   result_out/valid    captured result, held until result_ack
//   busy                sequencer is neither IDLE nor HOLD
//   err, err_clr        sticky protocol error and its clear
//   irq, irq_clr        completion interrupt and its clear
module dot_prod_vector_streamer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int RES_W  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W:0]   len,
   input  logic              go,
   output logic              init_loading_pulse,
   output logic              start,
   output logic [DATA_W-1:0] a_data,
   output logic [DATA_W-1:0] b_data,
   output logic              vector_valid,
   input  logic              vec_ready,
   output logic              last,
   input  logic              done_in,
   input  logic [RES_W-1:0]  result_in,
   output logic [RES_W-1:0]  result_out,
   output logic              result_valid,
   input  logic              result_ack,
   output logic              busy,
   output logic              err,
   input  logic              err_clr,
   output logic              irq,
   input  logic              irq_clr
);

   typedef enum logic [2:0] {IDLE, LOAD, ARM, STREAM, WAIT_DONE, HOLD} state_t;

   // idx and len_q carry one extra bit so a full-depth length is representable
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   mem_a [DEPTH];
   logic [DATA_W-1:0]   mem_b [DEPTH];
   logic [ADDR_W:0]     idx, len_q;
   logic                len_ok, mem_we, beat, at_last, go_ok, err_set;

   always_comb begin
      len_ok  = (len != '0) && (len <= DEPTH_L);
      go_ok   = (state == LOAD) && go && len_ok;
      mem_we  = wr_en && ((state == IDLE) || (state == LOAD));
      beat    = (state == STREAM) && vec_ready;
      at_last = (idx == (len_q - ONE));
      // IDLE ignores a stray done_in; every other non-waiting state flags it
      err_set = ((state == LOAD) && go && !len_ok)
              || (wr_en && ((state == STREAM) || (state == WAIT_DONE)))
              || (done_in && (state != WAIT_DONE) && (state != IDLE));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      start        = 1'b0;
      vector_valid = 1'b0;
      last         = 1'b0;
      a_data       = '0;
      b_data       = '0;
      result_valid = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (wr_en) state_nxt = LOAD;
         end
         LOAD: begin
            if (go_ok) state_nxt = ARM;
         end
         ARM: begin
            start     = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            vector_valid = 1'b1;
            last         = at_last;
            a_data       = mem_a[idx[ADDR_W-1:0]];
            b_data       = mem_b[idx[ADDR_W-1:0]];
            if (beat && at_last) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done_in) state_nxt = HOLD;
         end
         HOLD: begin
            busy         = 1'b0;
            result_valid = 1'b1;
            if (result_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] <= '0;
            mem_b[i] <= '0;
         end
         idx                <= '0;
         len_q              <= '0;
         result_out         <= '0;
         init_loading_pulse <= 1'b0;
         err                <= 1'b0;
      end else begin
         init_loading_pulse <= (state == IDLE) && wr_en;
         // a write in the same cycle as go lands before the first read in STREAM
         if (mem_we) begin
            if (wr_sel) mem_b[wr_addr] <= wr_data;
            else        mem_a[wr_addr] <= wr_data;
         end
         if (go_ok) begin
            len_q <= len;
            idx   <= '0;
         end else if (beat && !at_last) begin
            idx <= idx + ONE;
         end
         if ((state == WAIT_DONE) && done_in) result_out <= result_in;
         // a new error in the same cycle as err_clr keeps err set
         err <= err_set | (err & ~err_clr);
      end
   end

`ifdef STREAMER_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             irq_q <= 1'b0;
      else if ((state == WAIT_DONE) && done_in) irq_q <= 1'b1;
      else if (irq_clr)                      irq_q <= 1'b0;
   end
   assign irq = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = irq_clr;
   assign irq            = 1'b0;
`endif

endmodule
